// File: rtl/hpdcache_tb_misc_monitor_pkg.sv
// hpdcache_tb_misc_pkg: shared types and constants for the handshake monitor
package hpdcache_tb_misc_pkg;
  typedef enum logic [1:0] {SEL_XFER, SEL_STALL, SEL_MAX, SEL_STATUS} rd_sel_e;
  typedef enum logic {IDLE, RESP} rd_fsm_e;
  localparam int ST_STALL   = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_PROTO   = 2;
  function automatic int ch_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hpdcache_tb_misc_monitor_if.sv
// hpdcache_tb_misc_monitor_if: monitored channels, controls and statistics read port
interface hpdcache_tb_misc_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = hpdcache_tb_misc_pkg::ch_w(NUM_CH);
  logic              enable_i;
  logic              clear_i;
  logic [NUM_CH-1:0] ch_valid_i;
  logic [NUM_CH-1:0] ch_ready_i;
  logic              rd_req_i;
  logic [CH_W-1:0]   rd_ch_i;
  logic [1:0]        rd_sel_i;
  logic              rd_gnt_o;
  logic              rd_valid_o;
  logic [CNT_W-1:0]  rd_data_o;
  logic              rd_err_o;
  logic              rd_ack_i;
  logic [NUM_CH-1:0] timeout_o;
  logic [NUM_CH-1:0] proto_err_o;
  modport master (
    output enable_i, clear_i, ch_valid_i, ch_ready_i, rd_req_i, rd_ch_i, rd_sel_i, rd_ack_i,
    input  rd_gnt_o, rd_valid_o, rd_data_o, rd_err_o, timeout_o, proto_err_o
  );
  modport slave (
    input  enable_i, clear_i, ch_valid_i, ch_ready_i, rd_req_i, rd_ch_i, rd_sel_i, rd_ack_i,
    output rd_gnt_o, rd_valid_o, rd_data_o, rd_err_o, timeout_o, proto_err_o
  );
endinterface

// File: rtl/hpdcache_tb_misc_monitor_ch_stats.sv
// hpdcache_tb_ch_stats: saturating transfer/stall statistics and sticky flags for one channel
module hpdcache_tb_ch_stats #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             enable,
  input  logic             clear,
  input  logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] max_stall,
  output logic             stalling,
  output logic             timeout,
  output logic             proto_err
);
  localparam logic [CNT_W-1:0] TO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONES = '1;
  logic [CNT_W-1:0] run_len, run_nxt;
  logic             prev_stall;
  always_comb run_nxt = (valid & ~ready) ? (run_len == TO ? run_len : run_len + 1'b1) : '0;
  assign stalling = run_len != '0;
  always_ff @(posedge clk) begin
    if (!rst_ni || clear) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
      max_stall <= '0;
      run_len   <= '0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (enable) begin
        xfer_cnt  <= xfer_cnt + CNT_W'(valid & ready & (xfer_cnt != ONES));
        stall_cnt <= stall_cnt + CNT_W'(valid & ~ready & (stall_cnt != ONES));
        run_len   <= run_nxt;
        max_stall <= run_nxt > max_stall ? run_nxt : max_stall;
        timeout   <= timeout | (run_nxt == TO);
      end
      proto_err <= proto_err | (prev_stall & ~valid);
    end
  end
  // withdrawal tracking keeps sampling while statistics are frozen or cleared
  always_ff @(posedge clk) prev_stall <= rst_ni & valid & ~ready;
endmodule

// File: rtl/hpdcache_tb_misc_monitor.sv
// hpdcache_tb_misc_monitor: per-channel handshake statistics with a req/gnt + valid/ack read port
module hpdcache_tb_misc_monitor
  import hpdcache_tb_misc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input logic                    clk,
  input logic                    rst_ni,
  hpdcache_tb_misc_monitor_if.slave mon
);
  localparam int CH_W = ch_w(NUM_CH);
  logic [CNT_W-1:0]  xfer [NUM_CH];
  logic [CNT_W-1:0]  stall [NUM_CH];
  logic [CNT_W-1:0]  mx [NUM_CH];
  logic [NUM_CH-1:0] stalling, tout, proto;
  logic [CNT_W-1:0]  sel_data, st, rd_data;
  logic              sel_err, rd_err, accept;
  rd_sel_e           sel;
  rd_fsm_e           state, state_nxt;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    hpdcache_tb_ch_stats #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_ch (
      .clk       (clk),
      .rst_ni    (rst_ni),
      .enable    (mon.enable_i),
      .clear     (mon.clear_i),
      .valid     (mon.ch_valid_i[c]),
      .ready     (mon.ch_ready_i[c]),
      .xfer_cnt  (xfer[c]),
      .stall_cnt (stall[c]),
      .max_stall (mx[c]),
      .stalling  (stalling[c]),
      .timeout   (tout[c]),
      .proto_err (proto[c])
    );
  end
  assign mon.timeout_o   = tout;
  assign mon.proto_err_o = proto;
  assign sel             = rd_sel_e'(mon.rd_sel_i);
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    st       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mon.rd_ch_i == CH_W'(i)) begin
        st           = '0;
        st[ST_STALL]   = stalling[i];
        st[ST_TIMEOUT] = tout[i];
        st[ST_PROTO]   = proto[i];
        sel_err  = 1'b0;
        sel_data = sel == SEL_XFER  ? xfer[i]  :
                   sel == SEL_STALL ? stall[i] :
                   sel == SEL_MAX   ? mx[i]    : st;
      end
    end
  end
  always_ff @(posedge clk) state <= !rst_ni ? IDLE : state_nxt;
  always_comb state_nxt = state == IDLE ? (mon.rd_req_i ? RESP : IDLE) : (mon.rd_ack_i ? IDLE : RESP);
  always_comb begin
    mon.rd_gnt_o   = state == IDLE;
    mon.rd_valid_o = state == RESP;
  end
  assign accept = mon.rd_req_i & (state == IDLE);
  // snapshot taken from pre-edge register values; later clears cannot disturb it
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else if (accept) begin
      rd_data <= sel_data;
      rd_err  <= sel_err;
    end
  end
  assign mon.rd_data_o = rd_data;
  assign mon.rd_err_o  = rd_err;
endmodule

// File: tb/tb_hpdcache_tb_misc_monitor.sv
// tb_hpdcache_tb_misc_monitor: directed checks of statistics, flags and read port with a read scoreboard
module tb_hpdcache_tb_misc_monitor;
  import hpdcache_tb_misc_pkg::*;
  localparam int NUM_CH  = 5;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int CH_W    = 3;
  typedef struct packed {
    logic             err;
    logic [CNT_W-1:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;
  hpdcache_tb_misc_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) mon ();
  hpdcache_tb_misc_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .rst_ni (rst_ni),
    .mon    (mon)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic issue(int ch, rd_sel_e sel, logic [CNT_W-1:0] d, logic e);
    int n;
    sb.push_back(exp_t'{err: e, data: d});
    chk("gnt_idle", 32'(mon.rd_gnt_o), 1);
    mon.rd_req_i = 1'b1;
    mon.rd_ch_i  = CH_W'(ch);
    mon.rd_sel_i = sel;
    step(1);
    mon.rd_req_i = 1'b0;
    n = 0;
    while (!mon.rd_valid_o && n < 4) begin
      step(1);
      n++;
    end
    chk("valid_latency", n, 0);
    cur = sb.pop_front();
    chk($sformatf("rd_data ch%0d sel%0d", ch, sel), 32'(mon.rd_data_o), 32'(cur.data));
    chk($sformatf("rd_err ch%0d sel%0d", ch, sel), 32'(mon.rd_err_o), 32'(cur.err));
    chk("gnt_resp", 32'(mon.rd_gnt_o), 0);
  endtask
  task automatic finish(int delay);
    repeat (delay) begin
      step(1);
      chk("hold_valid", 32'(mon.rd_valid_o), 1);
      chk("hold_data", 32'(mon.rd_data_o), 32'(cur.data));
      chk("hold_err", 32'(mon.rd_err_o), 32'(cur.err));
    end
    mon.rd_ack_i = 1'b1;
    step(1);
    mon.rd_ack_i = 1'b0;
    chk("valid_drop", 32'(mon.rd_valid_o), 0);
  endtask
  task automatic read(int ch, rd_sel_e sel, logic [CNT_W-1:0] d, logic e);
    issue(ch, sel, d, e);
    finish(0);
  endtask
  initial begin
    mon.enable_i   = 1'b1;
    mon.clear_i    = 1'b0;
    mon.ch_valid_i = '0;
    mon.ch_ready_i = '0;
    mon.rd_req_i   = 1'b0;
    mon.rd_ch_i    = '0;
    mon.rd_sel_i   = '0;
    mon.rd_ack_i   = 1'b0;
    step(2);
    chk("rst_valid", 32'(mon.rd_valid_o), 0);
    chk("rst_data", 32'(mon.rd_data_o), 0);
    chk("rst_err", 32'(mon.rd_err_o), 0);
    chk("rst_timeout", 32'(mon.timeout_o), 0);
    chk("rst_proto", 32'(mon.proto_err_o), 0);
    rst_ni = 1'b1;
    step(1);
    read(0, SEL_XFER, 0, 0);
    // T1: ten fires on ch0
    mon.ch_valid_i[0] = 1'b1;
    mon.ch_ready_i[0] = 1'b1;
    step(10);
    mon.ch_valid_i[0] = 1'b0;
    mon.ch_ready_i[0] = 1'b0;
    read(0, SEL_XFER, 10, 0);
    read(0, SEL_STALL, 0, 0);
    read(0, SEL_STATUS, 0, 0);
    // T2: ch1 stalls for TIMEOUT cycles
    mon.ch_valid_i[1] = 1'b1;
    step(TIMEOUT - 1);
    chk("timeout_pre", 32'(mon.timeout_o[1]), 0);
    step(1);
    chk("timeout_rise", 32'(mon.timeout_o[1]), 1);
    mon.ch_ready_i[1] = 1'b1;
    step(1);
    mon.ch_valid_i[1] = 1'b0;
    mon.ch_ready_i[1] = 1'b0;
    step(1);
    chk("timeout_sticky", 32'(mon.timeout_o[1]), 1);
    chk("proto_ch1", 32'(mon.proto_err_o[1]), 0);
    read(1, SEL_MAX, 8, 0);
    read(1, SEL_STALL, 8, 0);
    read(1, SEL_XFER, 1, 0);
    read(1, SEL_STATUS, 4'b0010, 0);
    // T3: valid withdrawn on ch2
    mon.ch_valid_i[2] = 1'b1;
    step(1);
    mon.ch_valid_i[2] = 1'b0;
    step(1);
    chk("proto_ch2", 32'(mon.proto_err_o[2]), 1);
    read(2, SEL_STATUS, 4'b0100, 0);
    // T4: ch3 saturates at all-ones
    mon.ch_valid_i[3] = 1'b1;
    mon.ch_ready_i[3] = 1'b1;
    step(20);
    mon.ch_valid_i[3] = 1'b0;
    mon.ch_ready_i[3] = 1'b0;
    read(3, SEL_XFER, 15, 0);
    read(3, SEL_STALL, 0, 0);
    // stall in progress on ch4 shows in status bit 0
    mon.ch_valid_i[4] = 1'b1;
    step(1);
    read(4, SEL_STATUS, 4'b0001, 0);
    mon.ch_ready_i[4] = 1'b1;
    step(1);
    mon.ch_valid_i[4] = 1'b0;
    mon.ch_ready_i[4] = 1'b0;
    step(1);
    chk("timeout_vec", 32'(mon.timeout_o), 5'b00010);
    chk("proto_vec", 32'(mon.proto_err_o), 5'b00100);
    // T5: clear during RESP with same-cycle fire on ch0
    issue(0, SEL_XFER, 10, 0);
    mon.clear_i       = 1'b1;
    mon.ch_valid_i[0] = 1'b1;
    mon.ch_ready_i[0] = 1'b1;
    step(1);
    mon.clear_i       = 1'b0;
    mon.ch_valid_i[0] = 1'b0;
    mon.ch_ready_i[0] = 1'b0;
    chk("clear_hold_data", 32'(mon.rd_data_o), 10);
    finish(2);
    chk("clear_timeout", 32'(mon.timeout_o), 0);
    chk("clear_proto", 32'(mon.proto_err_o), 0);
    read(0, SEL_XFER, 0, 0);
    read(1, SEL_MAX, 0, 0);
    read(3, SEL_XFER, 0, 0);
    // T6: out-of-range channel, late ack, reset mid-read
    issue(NUM_CH, SEL_XFER, 0, 1);
    finish(5);
    mon.ch_valid_i[4] = 1'b1;
    mon.ch_ready_i[4] = 1'b1;
    step(2);
    mon.ch_valid_i[4] = 1'b0;
    mon.ch_ready_i[4] = 1'b0;
    issue(4, SEL_XFER, 2, 0);
    rst_ni = 1'b0;
    step(1);
    chk("rst_mid_valid", 32'(mon.rd_valid_o), 0);
    chk("rst_mid_data", 32'(mon.rd_data_o), 0);
    chk("rst_mid_err", 32'(mon.rd_err_o), 0);
    rst_ni = 1'b1;
    step(1);
    read(4, SEL_XFER, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
